am_lock_unit: RTL and testbench
===============================

Name: am_lock_unit

Overview:
- Per-lane alignment-marker lock for the 100GbE PCS receive path; one instance per PCS lane, after block sync and before lane reorder/deskew.
- Contains:
  - Clause-82-style AM lock FSM with a parametrised AM period.
  - Runtime-programmable invalid-AM limit.
  - Per-lane BIP3 checking with a saturating error counter.
  - Optional replacement of each AM block on the output by an idle control block.
- Successor of the single-lane comparator/timer/FSM arrangement.

Parameters:
- LEN_CODED_BLOCK, 66, coded block width (sync header + 64b payload)
- N_ALIGNER, 20, number of PCS lanes / entries in the AM table
- NB_LANE_ID, $clog2(N_ALIGNER), lane id width
- N_BLOCKS, 16383, valid blocks between consecutive AMs (AM period minus one)
- NB_BIP, 8, BIP width
- NB_ERROR_COUNTER, 32, BIP error counter width
- NB_INVALID, 4, width of invalid-AM limit and counter

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state and outputs
- i_valid  in  1  new block present on i_data this cycle
- i_block_lock  in  1  block lock from block sync
- i_data  in  LEN_CODED_BLOCK  coded block, [65:64] = sync header
- i_am_invalid_limit  in  NB_INVALID  consecutive bad AMs before resync (0 treated as 1)
- i_restore_am_en  in  1  replace accepted AMs by idle block on output
- i_clear_counters  in  1  synchronous clear of o_bip_error_count
- o_data  out  LEN_CODED_BLOCK  delayed data
- o_valid  out  1  o_data valid
- o_lane_id  out  NB_LANE_ID  locked lane id
- o_am_lock  out  1  AM lock achieved
- o_resync  out  1  one-cycle pulse on lock loss through the invalid-AM limit
- o_start_of_lane  out  1  one-cycle pulse aligned with o_valid of each accepted AM
- o_bip_error_count  out  NB_ERROR_COUNTER  saturating BIP3 mismatch count
- o_am_invalid_count  out  NB_INVALID  current consecutive invalid AM count

Behaviour:
- Reset values: all outputs 0; FSM in LOCK_INIT; timer 0; BIP accumulator 0.
- Clocking: all state updates require i_enable; block-driven updates additionally require i_valid.
- Block layout (payload):
  - M0 [63:56], M1 [55:48], M2 [47:40], BIP3 [39:32], M4 [31:24], M5 [23:16], M6 [15:8], BIP7 [7:0].
  - AM key = {M0,M1,M2,M4,M5,M6}.
  - A block is AM-shaped if sh == 2'b10 and the key equals a table entry.
- Comparison scope:
  - FIND_1ST compares the key against all N_ALIGNER entries; a unique hit stores its index.
  - All later states compare only against the stored entry.
- Timer:
  - Cleared on the block accepted in FIND_1ST/COMP states.
  - Increments on each valid block.
  - timer_done is true when the count equals N_BLOCKS, i.e. the expected AM position.
- FSM:
  - LOCK_INIT -> FIND_1ST when i_block_lock.
  - FIND_1ST: AM-shaped block -> COUNT_1.
  - COUNT_1: at timer_done the current block is evaluated (COMP_2ND). Match -> COUNT_2 with o_am_lock=1 and invalid count 0; mismatch -> FIND_1ST.
  - COUNT_2: at timer_done (COMP_AM), match -> invalid count 0, stay locked.
  - COUNT_2 mismatch: invalid count +1. If the new count >= limit -> FIND_1ST, o_am_lock=0, o_resync pulse, count 0. Otherwise stay in COUNT_2, lock held.
  - i_block_lock low in any state -> LOCK_INIT next cycle; o_am_lock=0; no o_resync.
- Output path:
  - Latency 1 valid cycle; o_valid = registered (i_valid & i_enable).
  - An accepted AM with i_restore_am_en=1 is output as {2'b10, 64'h0}.
- o_lane_id updates only on acceptance in FIND_1ST; held otherwise.
- BIP:
  - Accumulator bit j = XOR of bits i of each 66b block with i mod 8 == j.
  - Accumulation covers all blocks after an AM, up to and including the next AM with its BIP3/BIP7 fields zeroed.
  - While locked, on each accepted AM, a calculated value != received BIP3 increments the counter, saturating at all-ones.
  - The accumulator then restarts.
  - Mismatched AMs are not BIP-checked.
- i_clear_counters and a counter increment in the same cycle: clear wins.
- i_reset mid-operation returns everything to reset values next cycle.

Decomposition:
- Package pcs_am_pkg holds:
  - the AM key table (N_ALIGNER x 48b);
  - CTRL_SH and the idle block constant;
  - field offsets;
  - the FSM state encoding.
- One sub-module, am_bip_accumulator (accumulate / check / restart).

Test Plan:
- N_BLOCKS=4, lane 7 AM, block_lock=1, AMs every 5 valid blocks: o_am_lock rises after the 2nd AM; o_lane_id=7.
- Locked, limit=3, three consecutive corrupted AMs (M1 flipped): invalid count 1,2, then o_resync pulse; o_am_lock=0; FSM in FIND_1ST.
- Locked, one bad AM then a good AM: count 1 then 0; lock held; no resync.
- Lane 3 stream with BIP3 field XOR 8'h01 on every AM, three AMs: o_bip_error_count=2 (the first AM is not checked); clear -> 0.
- i_restore_am_en=1: accepted AM is output as 66'h2_0000_0000_0000_0000 one cycle later with o_start_of_lane=1.
- i_block_lock dropped while locked: o_am_lock=0 next cycle, no o_resync; i_enable=0 for 10 cycles freezes all outputs.

Source files
------------

// File: rtl/pcs_am_pkg.sv
// Shared constants for the per-lane alignment-marker lock: AM table, block
// field offsets, idle replacement block and lock FSM state encoding.
package pcs_am_pkg;

    localparam int N_AM_TABLE = 20;

    localparam logic [1:0]  CTRL_SH    = 2'b10;
    localparam logic [65:0] IDLE_BLOCK = {CTRL_SH, 64'h0};

    localparam int SH_LSB   = 64;
    localparam int M012_LSB = 40;
    localparam int BIP3_LSB = 32;
    localparam int M456_LSB = 8;
    localparam int BIP7_LSB = 0;

    localparam logic [65:0] BIP_FIELDS_MASK = {2'b00, 24'h0, 8'hFF, 24'h0, 8'hFF};

    typedef enum logic [1:0] {
        LOCK_INIT,
        FIND_1ST,
        COUNT_1,
        COUNT_2
    } am_state_e;

    // M0..M2 per lane; M4..M6 are their bitwise complements.
    function automatic logic [23:0] am_m012(input logic [4:0] idx);
        case (idx)
            5'd0:    return 24'hC16821;
            5'd1:    return 24'h9D718E;
            5'd2:    return 24'h594BE8;
            5'd3:    return 24'h4D957B;
            5'd4:    return 24'hF50709;
            5'd5:    return 24'hDD14C2;
            5'd6:    return 24'h9A4A26;
            5'd7:    return 24'h7B4566;
            5'd8:    return 24'hA02476;
            5'd9:    return 24'h68C9FB;
            5'd10:   return 24'hFD6C99;
            5'd11:   return 24'hB99155;
            5'd12:   return 24'h5CB9B2;
            5'd13:   return 24'h1AF8BD;
            5'd14:   return 24'h83C7CA;
            5'd15:   return 24'h3536CD;
            5'd16:   return 24'hC4314C;
            5'd17:   return 24'hADD6B7;
            5'd18:   return 24'h5F662A;
            5'd19:   return 24'hC0F0E5;
            default: return 24'h0;
        endcase
    endfunction

    function automatic logic [47:0] am_key(input logic [4:0] idx);
        logic [23:0] m;
        m = am_m012(idx);
        return {m, ~m};
    endfunction

endpackage

// File: rtl/am_bip_accumulator.sv
// Running BIP over the coded block stream; closes on each AM position, compares
// against the received BIP3 when asked and keeps a saturating error count.
module am_bip_accumulator
    import pcs_am_pkg::*;
#(
    parameter int LEN_CODED_BLOCK  = 66,
    parameter int NB_BIP           = 8,
    parameter int NB_ERROR_COUNTER = 32
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_step,
    input  logic [LEN_CODED_BLOCK-1:0]  i_data,
    input  logic                        i_close,
    input  logic                        i_check,
    input  logic                        i_clear,
    output logic [NB_ERROR_COUNTER-1:0] o_error_count
);

    logic [NB_BIP-1:0]          acc;
    logic [NB_BIP-1:0]          blk_fold;
    logic [NB_BIP-1:0]          am_fold;
    logic [NB_BIP-1:0]          calc;
    logic [LEN_CODED_BLOCK-1:0] am_zeroed;

    assign am_zeroed = i_data & ~LEN_CODED_BLOCK'(BIP_FIELDS_MASK);

    always_comb begin
        blk_fold = '0;
        am_fold  = '0;
        for (int i = 0; i < LEN_CODED_BLOCK; i++) begin
            blk_fold[i % NB_BIP] ^= i_data[i];
            am_fold[i % NB_BIP]  ^= am_zeroed[i];
        end
    end

    // The closing AM contributes with its own BIP fields zeroed.
    assign calc = acc ^ am_fold;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc           <= '0;
            o_error_count <= '0;
        end else begin
            if (i_step)
                acc <= i_close ? '0 : (acc ^ blk_fold);
            if (i_clear)
                o_error_count <= '0;
            else if (i_check && (calc != i_data[BIP3_LSB +: NB_BIP]) && (o_error_count != '1))
                o_error_count <= o_error_count + NB_ERROR_COUNTER'(1);
        end
    end

endmodule

// File: rtl/am_lock_unit.sv
// Per-lane alignment-marker lock: finds the lane's AM, confirms the period,
// tracks invalid AMs, checks BIP3 and optionally blanks AMs on the output.
module am_lock_unit
    import pcs_am_pkg::*;
#(
    parameter int LEN_CODED_BLOCK  = 66,
    parameter int N_ALIGNER        = 20,
    parameter int NB_LANE_ID       = $clog2(N_ALIGNER),
    parameter int N_BLOCKS         = 16383,
    parameter int NB_BIP           = 8,
    parameter int NB_ERROR_COUNTER = 32,
    parameter int NB_INVALID       = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic                        i_block_lock,
    input  logic [LEN_CODED_BLOCK-1:0]  i_data,
    input  logic [NB_INVALID-1:0]       i_am_invalid_limit,
    input  logic                        i_restore_am_en,
    input  logic                        i_clear_counters,
    output logic [LEN_CODED_BLOCK-1:0]  o_data,
    output logic                        o_valid,
    output logic [NB_LANE_ID-1:0]       o_lane_id,
    output logic                        o_am_lock,
    output logic                        o_resync,
    output logic                        o_start_of_lane,
    output logic [NB_ERROR_COUNTER-1:0] o_bip_error_count,
    output logic [NB_INVALID-1:0]       o_am_invalid_count
);

    localparam int                  NB_TIMER  = $clog2(N_BLOCKS + 1);
    localparam logic [NB_TIMER-1:0] TIMER_END = NB_TIMER'(N_BLOCKS);

    am_state_e             state;
    logic [NB_TIMER-1:0]   timer;
    logic [47:0]           key;
    logic [N_ALIGNER-1:0]  hits;
    logic [NB_LANE_ID-1:0] hit_idx;
    logic [NB_INVALID-1:0] limit_eff;
    logic [NB_INVALID-1:0] inv_next;
    logic step, sh_ok, hit_unique, match_stored, in_count, eval_am, find_acc, accept;

    assign step  = i_enable & i_valid;
    assign sh_ok = (i_data[SH_LSB +: 2] == CTRL_SH);
    assign key   = {i_data[M012_LSB +: 24], i_data[M456_LSB +: 24]};

    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 0; i < N_ALIGNER; i++) begin
            hits[i] = sh_ok && (key == am_key(5'(i)));
            if (hits[i])
                hit_idx = NB_LANE_ID'(i);
        end
    end

    assign hit_unique   = $onehot(hits);
    assign match_stored = sh_ok && (key == am_key(5'(o_lane_id)));
    assign in_count     = (state == COUNT_1) || (state == COUNT_2);

    // eval_am marks the block sitting at the expected AM position.
    assign eval_am  = step & i_block_lock & in_count & (timer == TIMER_END);
    assign find_acc = step & i_block_lock & (state == FIND_1ST) & hit_unique;
    assign accept   = find_acc | (eval_am & match_stored);

    assign limit_eff = (i_am_invalid_limit == '0) ? NB_INVALID'(1) : i_am_invalid_limit;
    assign inv_next  = o_am_invalid_count + NB_INVALID'(1);

    am_bip_accumulator #(
        .LEN_CODED_BLOCK  (LEN_CODED_BLOCK),
        .NB_BIP           (NB_BIP),
        .NB_ERROR_COUNTER (NB_ERROR_COUNTER)
    ) u_bip (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_step        (step),
        .i_data        (i_data),
        .i_close       (find_acc | eval_am),
        .i_check       (eval_am & match_stored),
        .i_clear       (i_enable & i_clear_counters),
        .o_error_count (o_bip_error_count)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state              <= LOCK_INIT;
            timer              <= '0;
            o_data             <= '0;
            o_valid            <= 1'b0;
            o_lane_id          <= '0;
            o_am_lock          <= 1'b0;
            o_resync           <= 1'b0;
            o_start_of_lane    <= 1'b0;
            o_am_invalid_count <= '0;
        end else if (i_enable) begin
            o_valid         <= i_valid;
            o_resync        <= 1'b0;
            o_start_of_lane <= accept;
            if (i_valid) begin
                o_data <= (accept && i_restore_am_en) ? LEN_CODED_BLOCK'(IDLE_BLOCK) : i_data;
                timer  <= (find_acc || eval_am) ? '0 : timer + NB_TIMER'(1);
            end
            if (!i_block_lock) begin
                state              <= LOCK_INIT;
                o_am_lock          <= 1'b0;
                o_am_invalid_count <= '0;
            end else begin
                case (state)
                    LOCK_INIT: state <= FIND_1ST;
                    FIND_1ST: if (find_acc) begin
                        state     <= COUNT_1;
                        o_lane_id <= hit_idx;
                    end
                    COUNT_1: if (eval_am) begin
                        if (match_stored) begin
                            state              <= COUNT_2;
                            o_am_lock          <= 1'b1;
                            o_am_invalid_count <= '0;
                        end else begin
                            state <= FIND_1ST;
                        end
                    end
                    COUNT_2: if (eval_am) begin
                        if (match_stored) begin
                            o_am_invalid_count <= '0;
                        end else if (inv_next >= limit_eff) begin
                            state              <= FIND_1ST;
                            o_am_lock          <= 1'b0;
                            o_resync           <= 1'b1;
                            o_am_invalid_count <= '0;
                        end else begin
                            o_am_invalid_count <= inv_next;
                        end
                    end
                    default: state <= LOCK_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_am_lock_unit.sv
// Randomized lane streams checked each cycle against a block-counting model
// of the AM lock, plus directed checks at the notable points.
module tb_am_lock_unit;

    localparam int NB = 4;

    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_valid, i_block_lock;
    logic [65:0] i_data;
    logic [3:0]  i_am_invalid_limit;
    logic        i_restore_am_en, i_clear_counters;
    logic [65:0] o_data;
    logic        o_valid, o_am_lock, o_resync, o_start_of_lane;
    logic [4:0]  o_lane_id;
    logic [31:0] o_bip_error_count;
    logic [3:0]  o_am_invalid_count;

    am_lock_unit #(.N_BLOCKS(NB)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_block_lock(i_block_lock), .i_data(i_data), .i_am_invalid_limit(i_am_invalid_limit),
        .i_restore_am_en(i_restore_am_en), .i_clear_counters(i_clear_counters),
        .o_data(o_data), .o_valid(o_valid), .o_lane_id(o_lane_id), .o_am_lock(o_am_lock),
        .o_resync(o_resync), .o_start_of_lane(o_start_of_lane),
        .o_bip_error_count(o_bip_error_count), .o_am_invalid_count(o_am_invalid_count)
    );

    always #5 i_clock = ~i_clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Lane marker table, M0..M2 (M4..M6 are complements).
    logic [23:0] amtab [20] = '{24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
                                24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
                                24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
                                24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};

    // model state: mode 0 init, 1 searching, 2 awaiting 2nd AM, 3 locked
    int          m_mode, m_pos, m_lane, m_inv;
    logic        m_lock;
    logic [7:0]  m_bip, gen_bip;
    logic [31:0] m_errs;
    logic [65:0] e_data;
    logic        e_valid, e_sol, e_resync;

    function automatic logic [7:0] bfold(input logic [65:0] d);
        logic [7:0] r = '0;
        for (int i = 0; i < 66; i++) r[i % 8] ^= d[i];
        return r;
    endfunction

    function automatic int lane_of(input logic [65:0] d);
        if (d[65:64] != 2'b10) return -1;
        for (int l = 0; l < 20; l++)
            if (d[63:40] == amtab[l] && d[31:8] == ~amtab[l]) return l;
        return -1;
    endfunction

    function automatic logic [65:0] rnd_blk();
        logic [1:0] sh = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        return {sh, 32'($urandom()), 32'($urandom())};
    endfunction

    task automatic model_step();
        int l;
        logic acc_find, ev, good;
        logic [7:0] calc;
        int lim;
        if (i_reset) begin
            m_mode = 0; m_pos = 0; m_lane = 0; m_inv = 0; m_lock = 0;
            m_bip = 0; m_errs = 0; e_data = '0; e_valid = 0; e_sol = 0; e_resync = 0;
            return;
        end
        if (!i_enable) return;
        e_resync = 0; e_sol = 0; e_valid = i_valid;
        acc_find = 0; ev = 0; good = 0; l = -1;
        if (i_valid && i_block_lock) begin
            if (m_mode == 1) begin
                l = lane_of(i_data);
                acc_find = (l >= 0);
            end else if (m_mode >= 2) begin
                m_pos++;
                if (m_pos == NB + 1) begin
                    ev = 1; m_pos = 0;
                    good = (lane_of(i_data) == m_lane);
                end
            end
        end
        if (i_valid) begin
            calc = m_bip ^ bfold({i_data[65:40], 8'h00, i_data[31:8], 8'h00});
            if (ev && good && calc != i_data[39:32] && m_errs != '1) m_errs++;
            m_bip = (acc_find || ev) ? 8'h00 : (m_bip ^ bfold(i_data));
            e_sol = acc_find || (ev && good);
            e_data = (e_sol && i_restore_am_en) ? {2'b10, 64'h0} : i_data;
        end
        if (i_clear_counters) m_errs = 0;
        lim = (i_am_invalid_limit == 0) ? 1 : int'(i_am_invalid_limit);
        if (!i_block_lock) begin
            m_mode = 0; m_lock = 0; m_inv = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (acc_find) begin m_mode = 2; m_lane = l; m_pos = 0; end
        end else if (ev) begin
            if (good) begin
                m_mode = 3; m_lock = 1; m_inv = 0;
            end else if (m_mode == 2) begin
                m_mode = 1;
            end else begin
                m_inv++;
                if (m_inv >= lim) begin m_mode = 1; m_lock = 0; m_resync_set(); m_inv = 0; end
            end
        end
    endtask

    task automatic m_resync_set();
        e_resync = 1;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_valid", 66'(o_valid), 66'(e_valid));
        chk("o_data", o_data, e_data);
        chk("o_lane_id", 66'(o_lane_id), 66'(m_lane));
        chk("o_am_lock", 66'(o_am_lock), 66'(m_lock));
        chk("o_resync", 66'(o_resync), 66'(e_resync));
        chk("o_start_of_lane", 66'(o_start_of_lane), 66'(e_sol));
        chk("o_bip_error_count", 66'(o_bip_error_count), 66'(m_errs));
        chk("o_am_invalid_count", 66'(o_am_invalid_count), 66'(m_inv));
    endtask

    task automatic cyc(input logic v, input logic [65:0] d);
        i_valid = v;
        i_data  = d;
        model_step();
        @(posedge i_clock);
        @(negedge i_clock);
        check_all();
    endtask

    task automatic blocks(input int n);
        logic [65:0] b;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) cyc(1'b0, rnd_blk());
            b = rnd_blk();
            gen_bip ^= bfold(b);
            cyc(1'b1, b);
        end
    endtask

    task automatic send_am(input int lane, input logic bad, input logic [7:0] bx);
        logic [65:0] am;
        logic [7:0]  b;
        am = {2'b10, amtab[lane], 8'h00, ~amtab[lane], 8'h00};
        if (bad) am[48] = ~am[48];
        b = gen_bip ^ bfold(am) ^ bx;
        am[39:32] = b;
        am[7:0]   = ~b;
        gen_bip   = 8'h00;
        cyc(1'b1, am);
    endtask

    task automatic period(input int lane, input logic bad, input logic [7:0] bx);
        blocks(NB);
        send_am(lane, bad, bx);
    endtask

    initial begin
        gen_bip = 8'h00;
        i_reset = 1; i_enable = 1; i_valid = 0; i_block_lock = 1; i_data = '0;
        i_am_invalid_limit = 4'd3; i_restore_am_en = 0; i_clear_counters = 0;
        cyc(1'b1, rnd_blk());
        cyc(1'b1, rnd_blk());
        chk("reset_lock", 66'(o_am_lock), 66'(0));
        chk("reset_data", o_data, 66'(0));
        chk("reset_valid", 66'(o_valid), 66'(0));
        chk("reset_bipcnt", 66'(o_bip_error_count), 66'(0));
        i_reset = 0;

        // lane 7 acquisition: lock after the second AM
        blocks(3);
        send_am(7, 0, 8'h00);
        chk("lane_id_7", 66'(o_lane_id), 66'(7));
        chk("no_lock_1st_am", 66'(o_am_lock), 66'(0));
        period(7, 0, 8'h00);
        chk("lock_after_2nd", 66'(o_am_lock), 66'(1));
        period(7, 0, 8'h00);
        period(7, 0, 8'h00);

        // one bad AM, then a good one
        period(7, 1, 8'h00);
        chk("inv_cnt_1", 66'(o_am_invalid_count), 66'(1));
        chk("lock_held", 66'(o_am_lock), 66'(1));
        period(7, 0, 8'h00);
        chk("inv_cnt_0", 66'(o_am_invalid_count), 66'(0));
        chk("no_resync", 66'(o_resync), 66'(0));

        // three bad AMs with limit 3
        period(7, 1, 8'h00);
        chk("inv_a", 66'(o_am_invalid_count), 66'(1));
        period(7, 1, 8'h00);
        chk("inv_b", 66'(o_am_invalid_count), 66'(2));
        period(7, 1, 8'h00);
        chk("resync_pulse", 66'(o_resync), 66'(1));
        chk("lock_lost", 66'(o_am_lock), 66'(0));
        chk("inv_reset", 66'(o_am_invalid_count), 66'(0));

        // lane 3 with corrupted BIP3 on every AM
        i_clear_counters = 1; cyc(1'b0, rnd_blk()); i_clear_counters = 0;
        period(3, 0, 8'h01);
        chk("lane_id_3", 66'(o_lane_id), 66'(3));
        period(3, 0, 8'h01);
        period(3, 0, 8'h01);
        chk("bip_errs_2", 66'(o_bip_error_count), 66'(2));
        blocks(NB);
        i_clear_counters = 1;
        send_am(3, 0, 8'h01);
        i_clear_counters = 0;
        chk("clear_wins", 66'(o_bip_error_count), 66'(0));
        period(3, 0, 8'h00);
        chk("bip_good", 66'(o_bip_error_count), 66'(0));

        // AM replacement
        i_restore_am_en = 1;
        period(3, 0, 8'h00);
        chk("restore_data", o_data, 66'h2_0000_0000_0000_0000);
        chk("restore_sol", 66'(o_start_of_lane), 66'(1));
        i_restore_am_en = 0;

        // block lock drop, then a frozen interval
        i_block_lock = 0;
        cyc(1'b1, rnd_blk());
        chk("bl_drop_lock", 66'(o_am_lock), 66'(0));
        chk("bl_drop_noresync", 66'(o_resync), 66'(0));
        i_block_lock = 1;
        cyc(1'b1, rnd_blk());
        i_enable = 0;
        for (int k = 0; k < 10; k++) begin
            i_block_lock = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), rnd_blk());
        end
        i_enable = 1; i_block_lock = 1;

        // limit 0 behaves as 1
        i_am_invalid_limit = 4'd0;
        gen_bip = 8'h00;
        blocks(2);
        send_am(11, 0, 8'h00);
        period(11, 0, 8'h00);
        chk("lock_lane11", 66'(o_am_lock), 66'(1));
        period(11, 1, 8'h00);
        chk("limit0_resync", 66'(o_resync), 66'(1));
        chk("limit0_unlock", 66'(o_am_lock), 66'(0));

        // reset mid-operation
        i_am_invalid_limit = 4'd3;
        blocks(1);
        send_am(5, 0, 8'h00);
        period(5, 0, 8'h00);
        chk("lock_lane5", 66'(o_am_lock), 66'(1));
        i_reset = 1;
        cyc(1'b1, rnd_blk());
        i_reset = 0;
        chk("rst_lock", 66'(o_am_lock), 66'(0));
        chk("rst_lane", 66'(o_lane_id), 66'(0));
        chk("rst_valid", 66'(o_valid), 66'(0));
        cyc(1'b0, rnd_blk());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
